button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the synchronous debounced level from button_deb (button_valid) and classifies user gestures.
- Emits one-cycle event pulses: press, release, single click, double click, long press.
- Sits between button_deb and the application control logic.
- Uses the same kHz clock-frequency convention as button_deb, so its timing is specified in milliseconds.

Parameters:
- CLK_FREQ, 95_000, clock frequency in kHz (clk cycles per ms); >= 2.
- LONG_MS, 500, hold time in ms that qualifies a long press; >= 1.
- DCLICK_MS, 250, maximum release-to-second-press gap in ms for a double click; >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- button_in  in  1  debounced level (button_valid of button_deb), synchronous to clk, 1 = pressed
- press_evt  out  1  one-cycle pulse on each 0->1 of button_in
- release_evt  out  1  one-cycle pulse on each 1->0 of button_in
- single_click  out  1  one-cycle pulse: short press not followed by a second press within DCLICK_MS
- double_click  out  1  one-cycle pulse: second press within DCLICK_MS of a short press's release
- long_press  out  1  one-cycle pulse: button held LONG_MS
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst = 0, async): FSM = IDLE, edge register = 0, prescaler and ms counter = 0, all outputs = 0.
- Edge detect:
  - button_in is registered once into prev.
  - rise = button_in & ~prev; fall = ~button_in & prev.
  - press_evt/release_evt are registered pulses, asserted the cycle after the edge is seen (latency 1).
- ms timebase:
  - Prescaler counts 0..CLK_FREQ-1; tick is high for one cycle when it wraps.
  - A ms counter of width clog2(max(LONG_MS, DCLICK_MS)+1) increments on tick and saturates.
  - Prescaler and ms counter both clear synchronously on every FSM state change (restart). This makes timing exact in cycles.
- FSM states and transitions (evaluated on rise/fall, same cycle as press_evt/release_evt assertion timing):
  - IDLE: rise -> PRESSED.
  - PRESSED:
    - fall -> WAIT2.
    - ms count reaches LONG_MS -> pulse long_press, -> HELD.
  - HELD: fall -> IDLE. No click event is generated.
  - WAIT2:
    - rise -> pulse double_click, -> PRESS2.
    - ms count reaches DCLICK_MS with no rise -> pulse single_click, -> IDLE.
  - PRESS2: fall -> IDLE. A long hold here generates no long_press.
- Cycle timing:
  - long_press is asserted exactly LONG_MS*CLK_FREQ cycles after press_evt.
  - single_click is asserted exactly DCLICK_MS*CLK_FREQ cycles after release_evt.
- Boundary cases:
  - Rise in the same cycle the WAIT2 timeout is reached: the rise wins; double_click, no single_click.
  - Fall in the same cycle LONG_MS is reached: the fall wins; -> WAIT2, no long_press.
- Event exclusivity: at most one of single_click/double_click/long_press is high in any cycle. press_evt/release_evt are independent of the classification pulses.
- Reset mid-gesture: all state is lost, with no event emitted on exit.
  - If button_in is already 1 when rst is released, prev is 0, so a rise (press_evt) is seen one cycle after reset release.
- Counter widths are sized from the parameters; there is no wrap at the 95 MHz default.

Decomposition:
- Package button_pkg:
  - state encoding constants (IDLE, PRESSED, HELD, WAIT2, PRESS2; 3 bits);
  - a clog2 function;
  - default timing constants shared with button_deb.
- Sub-module ms_tick (params CLK_FREQ; ports clk, rst, clr, tick): prescaler with synchronous clear. It is reusable by button_deb.

Test Plan (CLK_FREQ=10, LONG_MS=5, DCLICK_MS=3, i.e. 10 cycles/ms):
- Reset with button_in=1, then release rst -> press_evt 1 cycle later; all other outputs 0 during reset.
- Press 20 cycles, release, idle 40 cycles -> press_evt, release_evt, then single_click exactly 30 cycles after release_evt; no double/long.
- Press 20, release 15, press 20, release -> double_click on the 2nd press_evt cycle; no single_click at any time.
- Hold 80 cycles -> long_press exactly 50 cycles after press_evt; release -> release_evt only, busy drops.
- Release at cycle 50 of the hold (coincident with the LONG_MS limit) -> no long_press; single_click 30 cycles later.
- Assert rst during WAIT2 -> all outputs 0, busy 0, no single_click after rst release.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and timing defaults for the button front end (button_deb, button_event).
package button_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT    = 95_000;  // kHz, clk cycles per ms
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;
  localparam int unsigned LONG_MS_DEFAULT     = 500;
  localparam int unsigned DCLICK_MS_DEFAULT   = 250;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_HELD    = 3'd2,
    ST_WAIT2   = 3'd3,
    ST_PRESS2  = 3'd4
  } state_t;

  // Bits needed to represent values 0..value-1; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
        width = width + 1;
      end
    end
    return width;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: tick is high for one cycle each time the counter wraps at CLK_FREQ-1.
module ms_tick
  import button_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW   = clog2(CLK_FREQ);
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/button_event.sv
// Gesture classifier on the debounced button level: press/release edges plus
// single click, double click and long press pulses.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int unsigned LONG_MS   = LONG_MS_DEFAULT,
  parameter int unsigned DCLICK_MS = DCLICK_MS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic press_evt,
  output logic release_evt,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  localparam int unsigned    MS_MAX      = max_u(LONG_MS, DCLICK_MS);
  localparam int unsigned    MSW         = clog2(MS_MAX + 1);
  localparam logic [MSW-1:0] LONG_LAST   = MSW'(LONG_MS - 1);
  localparam logic [MSW-1:0] DCLICK_LAST = MSW'(DCLICK_MS - 1);

  state_t         state_q, state_d;
  logic           prev;
  logic           rise, fall;
  logic           tick, restart;
  logic [MSW-1:0] ms_cnt;
  logic           long_hit, dclick_hit;
  logic           single_d, double_d, long_d;

  assign rise = button_in & ~prev;
  assign fall = ~button_in & prev;

  ms_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_ms_tick (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .tick(tick)
  );

  // Limits fire on the tick that carries ms_cnt onto the limit, so the
  // registered pulse lands exactly N*CLK_FREQ cycles after state entry.
  assign long_hit   = tick && (ms_cnt == LONG_LAST);
  assign dclick_hit = tick && (ms_cnt == DCLICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_cnt <= '0;
    end else if (restart) begin
      ms_cnt <= '0;
    end else if (tick && (ms_cnt != '1)) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      prev         <= 1'b0;
      press_evt    <= 1'b0;
      release_evt  <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev         <= button_in;
      press_evt    <= rise;
      release_evt  <= fall;
      single_click <= single_d;
      double_click <= double_d;
      long_press   <= long_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      ST_WAIT2: begin
        if (rise) begin
          double_d = 1'b1;
          state_d  = ST_PRESS2;
        end else if (dclick_hit) begin
          single_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign restart = (state_d != state_q);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event at 10 cycles/ms, LONG_MS=5, DCLICK_MS=3.
module tb_button_event;

  logic clk = 1'b0;
  logic rst;
  logic button_in;
  logic press_evt, release_evt, single_click, double_click, long_press, busy;

  int total = 0;
  int bad   = 0;

  // observation state, refreshed by step()
  int cyc = 0;
  int n_press, n_rel, n_single, n_double, n_long, n_excl;
  int t_press, t_rel, t_single, t_double, t_long;

  button_event #(
    .CLK_FREQ (10),
    .LONG_MS  (5),
    .DCLICK_MS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_in   (button_in),
    .press_evt   (press_evt),
    .release_evt (release_evt),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_obs();
    n_press = 0; n_rel = 0; n_single = 0; n_double = 0; n_long = 0; n_excl = 0;
    t_press = -1; t_rel = -1; t_single = -1; t_double = -1; t_long = -1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (press_evt)    begin n_press++;  t_press  = cyc; end
      if (release_evt)  begin n_rel++;    t_rel    = cyc; end
      if (single_click) begin n_single++; t_single = cyc; end
      if (double_click) begin n_double++; t_double = cyc; end
      if (long_press)   begin n_long++;   t_long   = cyc; end
      if ((32'(single_click) + 32'(double_click) + 32'(long_press)) > 1) n_excl++;
    end
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst = 1'b0;
    button_in = 1'b1;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    outs = {press_evt, release_evt, single_click, double_click, long_press, busy};
    total++;
    if (outs !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", outs, 6'b0); end
    rst = 1'b1;
    #1;
    total++;
    if (press_evt !== 1'b0) begin bad++; $display("FAIL reset_release_no_press got=%b want=0", press_evt); end
    step(1);
    total++;
    if (press_evt !== 1'b1) begin bad++; $display("FAIL press_after_reset got=%b want=1", press_evt); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_reset_press got=%b want=1", busy); end
    button_in = 1'b0;
    step(50);
  endtask

  task automatic test_single();
    clear_obs();
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(40);
    total++;
    if (n_press !== 1 || n_rel !== 1) begin bad++; $display("FAIL single_edges got=%0d/%0d want=1/1", n_press, n_rel); end
    total++;
    if (t_rel - t_press !== 20) begin bad++; $display("FAIL single_press_len got=%0d want=20", t_rel - t_press); end
    total++;
    if (n_single !== 1 || t_single - t_rel !== 30) begin
      bad++; $display("FAIL single_click_time got=n%0d/d%0d want=n1/d30", n_single, t_single - t_rel);
    end
    total++;
    if (n_double !== 0 || n_long !== 0) begin bad++; $display("FAIL single_no_other got=%0d/%0d want=0/0", n_double, n_long); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_double();
    clear_obs();
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(15);
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(40);
    total++;
    if (n_press !== 2 || n_rel !== 2) begin bad++; $display("FAIL double_edges got=%0d/%0d want=2/2", n_press, n_rel); end
    total++;
    if (n_double !== 1 || t_double !== t_press) begin
      bad++; $display("FAIL double_click_time got=n%0d/t%0d want=n1/t%0d", n_double, t_double, t_press);
    end
    total++;
    if (n_single !== 0 || n_long !== 0) begin bad++; $display("FAIL double_no_other got=%0d/%0d want=0/0", n_single, n_long); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL double_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_long();
    clear_obs();
    button_in = 1'b1; step(80);
    total++;
    if (n_long !== 1 || t_long - t_press !== 50) begin
      bad++; $display("FAIL long_press_time got=n%0d/d%0d want=n1/d50", n_long, t_long - t_press);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL long_busy_held got=%b want=1", busy); end
    button_in = 1'b0; step(1);
    total++;
    if (release_evt !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL long_release got=rel%b/busy%b want=rel1/busy0", release_evt, busy);
    end
    step(40);
    total++;
    if (n_single !== 0 || n_double !== 0 || n_long !== 1) begin
      bad++; $display("FAIL long_no_click got=s%0d/d%0d/l%0d want=s0/d0/l1", n_single, n_double, n_long);
    end
  endtask

  task automatic test_long_boundary();
    clear_obs();
    button_in = 1'b1; step(50);
    button_in = 1'b0; step(40);
    total++;
    if (t_rel - t_press !== 50) begin bad++; $display("FAIL bnd_long_release_at got=%0d want=50", t_rel - t_press); end
    total++;
    if (n_long !== 0) begin bad++; $display("FAIL bnd_long_no_long got=%0d want=0", n_long); end
    total++;
    if (n_single !== 1 || t_single - t_rel !== 30) begin
      bad++; $display("FAIL bnd_long_single got=n%0d/d%0d want=n1/d30", n_single, t_single - t_rel);
    end
  endtask

  task automatic test_dclick_boundary();
    int r;
    clear_obs();
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(1);
    r = t_rel;
    step(29);
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(40);
    total++;
    if (n_double !== 1 || t_double - r !== 30) begin
      bad++; $display("FAIL bnd_dclick_double got=n%0d/d%0d want=n1/d30", n_double, t_double - r);
    end
    total++;
    if (n_single !== 0) begin bad++; $display("FAIL bnd_dclick_no_single got=%0d want=0", n_single); end
  endtask

  task automatic test_reset_wait2();
    logic [5:0] outs;
    clear_obs();
    button_in = 1'b1; step(20);
    button_in = 1'b0; step(5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_wait2_busy_before got=%b want=1", busy); end
    rst = 1'b0;
    #2;
    outs = {press_evt, release_evt, single_click, double_click, long_press, busy};
    total++;
    if (outs !== 6'b0) begin bad++; $display("FAIL rst_wait2_outputs got=%b want=%b", outs, 6'b0); end
    step(2);
    rst = 1'b1;
    clear_obs();
    step(50);
    total++;
    if (n_single !== 0 || n_press !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_wait2_after got=s%0d/p%0d/busy%b want=s0/p0/busy0", n_single, n_press, busy);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (n_excl !== 0) begin bad++; $display("FAIL exclusive got=%0d want=0", n_excl); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exclusive();
    test_double();
    test_exclusive();
    test_long();
    test_long_boundary();
    test_exclusive();
    test_dclick_boundary();
    test_exclusive();
    test_reset_wait2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
